// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
// Holds the format enum and the RV32I/RV64I major opcodes it decodes.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instr -> sign-extended imm, fmt, illegal.
// Ports: instr (32) in; imm (XLEN), fmt (fmt_e), illegal out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] ERR_FILL = '1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic        s;
  logic [63:0] imm64;

  assign s = instr[31];

  // Built at 64 bits and truncated so the same
  // expressions serve both XLEN values.
  always_comb begin
    imm64   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        imm64 = {{52{s}}, instr[31:20]};
        fmt   = FMT_I;
      end
      OPC_STORE: begin
        imm64 = {{52{s}}, instr[31:25], instr[11:7]};
        fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        imm64 = {{51{s}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm64 = {{32{s}}, instr[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OPC_JAL: begin
        imm64 = {{43{s}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      OPC_OP: begin
        imm64 = '0;
        fmt   = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    imm = illegal ? ERR_FILL : imm64[XLEN-1:0];
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready flow control and
// a saturating illegal-opcode counter.
// Ports: clk, rst (async high), flush; in_valid/in_ready/instr;
// out_valid/out_ready/imm/fmt/illegal; err_clr/err_cnt.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              PIPE_DEPTH = 1,
  parameter logic [XLEN-1:0] ERR_FILL   = '1,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output fmt_e             fmt,
  output logic             illegal,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } stage_t;

  logic [XLEN-1:0]       dec_imm;
  fmt_e                  dec_fmt;
  logic                  dec_il;
  stage_t                st [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] v;
  logic [PIPE_DEPTH-1:0] rdy;
  logic                  acc;

  imm_decode #(
    .XLEN    (XLEN),
    .ERR_FILL(ERR_FILL)
  ) u_dec (
    .instr  (instr),
    .imm    (dec_imm),
    .fmt    (dec_fmt),
    .illegal(dec_il)
  );

  // A stage can load when the consumer takes the
  // output or any stage at or after it is empty:
  // a hole downstream lets the whole chain shift.
  always_comb begin
    logic full;
    full = 1'b1;
    rdy  = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      full   = full & v[k];
      rdy[k] = out_ready | ~full;
    end
  end

  assign in_ready = rdy[0];
  assign acc      = in_valid & rdy[0] & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        st[k] <= '{imm: '0, fmt: FMT_NONE,
                   illegal: 1'b0};
      end
    end else begin
      if (rdy[0]) begin
        v[0]  <= acc;
        st[0] <= '{imm: dec_imm, fmt: dec_fmt,
                   illegal: dec_il};
      end
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        if (rdy[k]) begin
          v[k]  <= v[k-1];
          st[k] <= st[k-1];
        end
      end
      if (flush) begin
        v <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (acc && dec_il && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign out_valid = v[PIPE_DEPTH-1];
  assign imm       = st[PIPE_DEPTH-1].imm;
  assign fmt       = st[PIPE_DEPTH-1].fmt;
  assign illegal   = st[PIPE_DEPTH-1].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations share one stimulus stream
// and each is scored against its own arithmetic reference model.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, err_clr;
  logic [31:0] instr;

  logic ir0, ir1, ir2, ov0, ov1, ov2, il0, il1, il2;
  logic [31:0] imm0, imm1;
  logic [63:0] imm2;
  fmt_e fm0, fm1, fm2;
  logic [15:0] ec0, ec1;
  logic [1:0]  ec2;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .instr(instr),
    .out_valid(ov0), .out_ready(out_ready),
    .imm(imm0), .fmt(fm0), .illegal(il0),
    .err_clr(err_clr), .err_cnt(ec0));

  imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(3), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .instr(instr),
    .out_valid(ov1), .out_ready(out_ready),
    .imm(imm1), .fmt(fm1), .illegal(il1),
    .err_clr(err_clr), .err_cnt(ec1));

  imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .instr(instr),
    .out_valid(ov2), .out_ready(out_ready),
    .imm(imm2), .fmt(fm2), .illegal(il2),
    .err_clr(err_clr), .err_cnt(ec2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int dep[3] = '{1, 3, 2};
  int xl[3]  = '{32, 32, 64};
  int cmx[3] = '{65535, 65535, 3};

  logic [63:0] q_im [3][64];
  logic [2:0]  q_fm [3][64];
  logic        q_il [3][64];
  int hd[3], tl[3], cnt_m[3], n_acc[3], n_pop[3];

  function automatic void ref_dec(input logic [31:0] w,
                                  input int xlen,
                                  output logic [63:0] im,
                                  output logic [2:0] fm,
                                  output logic il);
    longint sw, val;
    sw  = longint'($signed(w));
    val = 0;
    il  = 1'b0;
    fm  = FMT_NONE;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin
        val = sw >>> 20;
        fm  = FMT_I;
      end
      7'h23: begin
        val = (sw >>> 25) * 32 + longint'(w[11:7]);
        fm  = FMT_S;
      end
      7'h63: begin
        val = (w[31] ? -64'sd4096 : 64'sd0)
            + longint'(w[7]) * 2048
            + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2;
        fm  = FMT_B;
      end
      7'h37, 7'h17: begin
        val = (sw >>> 12) * 4096;
        fm  = FMT_U;
      end
      7'h6F: begin
        val = (w[31] ? -64'sd1048576 : 64'sd0)
            + longint'(w[19:12]) * 4096
            + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2;
        fm  = FMT_J;
      end
      7'h33: begin
        val = 0;
        fm  = FMT_R;
      end
      default: begin
        val = -1;
        il  = 1'b1;
      end
    endcase
    im = val;
    if (xlen == 32) im[63:32] = '0;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 3; d++) begin
      hd[d] = 0; tl[d] = 0; cnt_m[d] = 0;
      n_acc[d] = 0; n_pop[d] = 0;
    end
  endtask

  task automatic mon(input int d, input logic ov,
                     input logic ir, input logic [63:0] im,
                     input logic [2:0] fm, input logic il,
                     input logic [63:0] ec);
    int occ, slot;
    logic [63:0] eim;
    logic [2:0]  efm;
    logic        eil, acc;
    occ  = tl[d] - hd[d];
    slot = hd[d] % 64;
    chk($sformatf("in_ready[%0d]", d), ir,
        out_ready || occ < dep[d]);
    chk($sformatf("err_cnt[%0d]", d), ec, cnt_m[d]);
    if (occ == 0) begin
      chk($sformatf("idle_valid[%0d]", d), ov, 0);
    end else if (ov) begin
      chk($sformatf("imm[%0d]", d), im, q_im[d][slot]);
      chk($sformatf("fmt[%0d]", d), fm, q_fm[d][slot]);
      chk($sformatf("ill[%0d]", d), il, q_il[d][slot]);
    end
    if (flush) begin
      hd[d] = tl[d];
    end else if (ov && out_ready && occ > 0) begin
      hd[d]++;
      n_pop[d]++;
    end
    acc = in_valid && ir && !flush;
    eil = 1'b0;
    if (acc) begin
      ref_dec(instr, xl[d], eim, efm, eil);
      q_im[d][tl[d] % 64] = eim;
      q_fm[d][tl[d] % 64] = efm;
      q_il[d][tl[d] % 64] = eil;
      tl[d]++;
      n_acc[d]++;
    end
    if (err_clr) cnt_m[d] = 0;
    else if (acc && eil && cnt_m[d] < cmx[d]) cnt_m[d]++;
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, ov0, ir0, {32'b0, imm0}, fm0, il0, {48'b0, ec0});
    mon(1, ov1, ir1, {32'b0, imm1}, fm1, il1, {48'b0, ec1});
    mon(2, ov2, ir2, imm2, fm2, il2, {62'b0, ec2});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 0; in_valid = 0; err_clr = 0; out_ready = 1;
    rst = 1;
    @(posedge clk);
    #2;
    rst = 0;
    reset_model();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [31:0] w,
                        input logic [31:0] e32,
                        input logic [63:0] e64,
                        input logic [2:0] ef);
    int lat[3];
    lat = '{0, 0, 0};
    instr = w; in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      if (ov0 && lat[0] == 0) begin
        lat[0] = c;
        chk("dir_imm0", {32'b0, imm0}, {32'b0, e32});
        chk("dir_fmt0", fm0, ef);
      end
      if (ov1 && lat[1] == 0) begin
        lat[1] = c;
        chk("dir_imm1", {32'b0, imm1}, {32'b0, e32});
        chk("dir_fmt1", fm1, ef);
      end
      if (ov2 && lat[2] == 0) begin
        lat[2] = c;
        chk("dir_imm2", imm2, e64);
        chk("dir_fmt2", fm2, ef);
      end
      step();
    end
    chk("latency0", lat[0], 1);
    chk("latency1", lat[1], 3);
    chk("latency2", lat[2], 2);
  endtask

  logic [6:0] opcs[9] = '{7'h03, 7'h13, 7'h67, 7'h23,
                          7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    rst = 1; flush = 0; in_valid = 0;
    out_ready = 0; err_clr = 0; instr = '0;
    #8;
    rst = 0;
    reset_model();
    chk("rst_valid0", ov0, 0);
    chk("rst_valid1", ov1, 0);
    chk("rst_valid2", ov2, 0);
    chk("rst_imm1", {32'b0, imm1}, 0);
    chk("rst_imm2", imm2, 0);
    chk("rst_fmt0", fm0, FMT_NONE);
    chk("rst_fmt2", fm2, FMT_NONE);
    chk("rst_ill1", il1, 0);
    chk("rst_cnt1", {48'b0, ec1}, 0);
    chk("rst_cnt2", {62'b0, ec2}, 0);
    chk("rst_ready1", ir1, 1);
    @(posedge clk);
    #1;

    single(32'hFFC12083, 32'hFFFFFFFC,
           64'hFFFFFFFFFFFFFFFC, FMT_I);
    single(32'h800000B7, 32'h80000000,
           64'hFFFFFFFF80000000, FMT_U);
    single(32'hFE000CE3, 32'hFFFFFFF8,
           64'hFFFFFFFFFFFFFFF8, FMT_B);
    single(32'h0010006F, 32'h00000800,
           64'h0000000000000800, FMT_J);
    single(32'h00A12423, 32'h8, 64'h8, FMT_S);
    single(32'h00208033, 32'h0, 64'h0, FMT_R);
    single(32'h0000007F, 32'hFFFFFFFF,
           64'hFFFFFFFFFFFFFFFF, FMT_NONE);

    // back-to-back with a consumer stall
    do_reset();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (n_pop[1] >= 8) break;
      in_valid  = n_acc[1] < 8;
      instr     = 32'h00000013 | ((n_acc[1] + 1) << 20);
      out_ready = !(cyc >= 4 && cyc <= 6);
      step();
    end
    chk("b2b_pops", n_pop[1], 8);
    chk("b2b_accepts", n_acc[1], 8);

    // illegal counting, clear priority, saturation
    do_reset();
    instr = 32'h0000007F; in_valid = 1;
    repeat (3) step();
    in_valid = 0;
    chk("ill_cnt1", {48'b0, ec1}, 3);
    chk("ill_cnt2", {62'b0, ec2}, 3);
    step();
    chk("ill_flag1", il1, 1);
    chk("ill_fill1", {32'b0, imm1}, 64'hFFFFFFFF);
    err_clr = 1; in_valid = 1;
    step();
    err_clr = 0; in_valid = 0;
    chk("clr_cnt1", {48'b0, ec1}, 0);
    chk("clr_cnt2", {62'b0, ec2}, 0);
    in_valid = 1;
    repeat (5) step();
    in_valid = 0;
    chk("sat_cnt2", {62'b0, ec2}, 3);
    chk("cnt5_cnt1", {48'b0, ec1}, 5);
    repeat (4) step();

    // flush with entries in flight and a new offer
    do_reset();
    out_ready = 0; in_valid = 1; instr = 32'hFFC12083;
    repeat (2) step();
    instr = 32'h0000007F; flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flush_valid0", ov0, 0);
    chk("flush_valid1", ov1, 0);
    chk("flush_valid2", ov2, 0);
    chk("flush_cnt1", {48'b0, ec1}, 0);
    out_ready = 1;
    repeat (2) step();

    // asynchronous reset mid-stream
    in_valid = 1; instr = 32'h00500093;
    repeat (4) step();
    chk("pre_rst_valid1", ov1, 1);
    rst = 1;
    #1;
    chk("arst_valid0", ov0, 0);
    chk("arst_valid1", ov1, 0);
    chk("arst_valid2", ov2, 0);
    in_valid = 0;
    reset_model();
    #2;
    rst = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      instr = $urandom;
      if ($urandom_range(0, 9) != 0)
        instr[6:0] = opcs[$urandom_range(0, 8)];
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 49) == 0;
      err_clr   = $urandom_range(0, 99) == 0;
      step();
    end
    flush = 0; in_valid = 0; err_clr = 0; out_ready = 1;
    repeat (6) step();
    chk("drain0", tl[0] - hd[0], 0);
    chk("drain1", tl[1] - hd[1], 0);
    chk("drain2", tl[2] - hd[2], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
